// File: rtl/bus_decoder_if.sv
// Pipelined Wishbone bundle shared by the CPU-side port and each device port.
// The master drives the request fields; the slave returns ack, stall and read data.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        stall;

  modport master (output cyc, stb, we, adr, sel, dat_w,
                  input  dat_r, ack, stall);
  modport slave  (input  cyc, stb, we, adr, sel, dat_w,
                  output dat_r, ack, stall);
endinterface

// File: rtl/bus_decoder.sv
// Pipelined Wishbone address decoder: one CPU master port fanned out to four devices,
// in-order responses tracked by a target-ID FIFO, and an internal responder for unmapped space.
module bus_decoder #(
  parameter int          DEPTH         = 4,
  parameter logic [3:0]  BASE0         = 4'h0,
  parameter logic [3:0]  BASE1         = 4'h2,
  parameter logic [3:0]  BASE2         = 4'h3,
  parameter logic [3:0]  BASE3         = 4'h8,
  parameter logic [31:0] UNMAPPED_DATA = 32'hDEADBEEF
) (
  input logic   clk_i,
  input logic   rst_i,
  if_wb.slave   cpu_bus,
  if_wb.master  dev0,
  if_wb.master  dev1,
  if_wb.master  dev2,
  if_wb.master  dev3
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [2:0]    id_q [DEPTH];

  logic [2:0]  tgt;
  logic [2:0]  head;
  logic        busy;
  logic        full;
  logic        stall_int;
  logic        dev_stall_sel;
  logic        head_ack;
  logic        accept;
  logic        pop;
  logic [3:0]  dev_stall;
  logic [3:0]  dev_ack;
  logic [3:0]  dev_stb;
  logic [3:0]  dev_cyc;
  logic [31:0] dev_dat [4];

  assign dev_stall  = {dev3.stall, dev2.stall, dev1.stall, dev0.stall};
  assign dev_ack    = {dev3.ack, dev2.ack, dev1.ack, dev0.ack};
  assign dev_dat[0] = dev0.dat_r;
  assign dev_dat[1] = dev1.dat_r;
  assign dev_dat[2] = dev2.dat_r;
  assign dev_dat[3] = dev3.dat_r;

  // Lowest-numbered region wins when bases collide; 4 means no device owns the address.
  always_comb begin
    tgt = 3'd4;
    if      (cpu_bus.adr[31:28] == BASE0) tgt = 3'd0;
    else if (cpu_bus.adr[31:28] == BASE1) tgt = 3'd1;
    else if (cpu_bus.adr[31:28] == BASE2) tgt = 3'd2;
    else if (cpu_bus.adr[31:28] == BASE3) tgt = 3'd3;
  end

  assign head          = id_q[rd_ptr];
  assign busy          = (count != '0);
  assign full          = (count == CW'(DEPTH));
  assign stall_int     = full | (busy & (head != tgt));
  assign dev_stall_sel = tgt[2] ? 1'b0 : dev_stall[tgt[1:0]];

  // Every output is forced idle while reset is held, independent of the clock.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      dev_stb[k] = rst_i & cpu_bus.cyc & cpu_bus.stb & (tgt == 3'(k)) & ~stall_int;
      dev_cyc[k] = rst_i & cpu_bus.cyc & ((tgt == 3'(k)) | (busy & (head == 3'(k))));
    end
  end

  assign head_ack      = head[2] ? 1'b1 : dev_ack[head[1:0]];
  assign cpu_bus.ack   = rst_i & cpu_bus.cyc & busy & head_ack;
  assign cpu_bus.stall = rst_i & (stall_int | dev_stall_sel);
  assign cpu_bus.dat_r = !cpu_bus.ack ? 32'h0
                       : (head[2] ? UNMAPPED_DATA : dev_dat[head[1:0]]);

  assign accept = rst_i & cpu_bus.cyc & cpu_bus.stb & ~cpu_bus.stall;
  assign pop    = cpu_bus.ack;

  assign dev0.cyc   = dev_cyc[0];
  assign dev0.stb   = dev_stb[0];
  assign dev0.we    = cpu_bus.we;
  assign dev0.adr   = cpu_bus.adr;
  assign dev0.sel   = cpu_bus.sel;
  assign dev0.dat_w = cpu_bus.dat_w;

  assign dev1.cyc   = dev_cyc[1];
  assign dev1.stb   = dev_stb[1];
  assign dev1.we    = cpu_bus.we;
  assign dev1.adr   = cpu_bus.adr;
  assign dev1.sel   = cpu_bus.sel;
  assign dev1.dat_w = cpu_bus.dat_w;

  assign dev2.cyc   = dev_cyc[2];
  assign dev2.stb   = dev_stb[2];
  assign dev2.we    = cpu_bus.we;
  assign dev2.adr   = cpu_bus.adr;
  assign dev2.sel   = cpu_bus.sel;
  assign dev2.dat_w = cpu_bus.dat_w;

  assign dev3.cyc   = dev_cyc[3];
  assign dev3.stb   = dev_stb[3];
  assign dev3.we    = cpu_bus.we;
  assign dev3.adr   = cpu_bus.adr;
  assign dev3.sel   = cpu_bus.sel;
  assign dev3.dat_w = cpu_bus.dat_w;

  // Dropping cyc abandons everything in flight; late device acks then find an empty queue.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!cpu_bus.cyc) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) id_q[wr_ptr] <= tgt;
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: directed scenarios plus random traffic,
// all compared every cycle against a queue-based model of outstanding targets.
module tb_bus_decoder;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_i;

  if_wb cpu ();
  if_wb d0 ();
  if_wb d1 ();
  if_wb d2 ();
  if_wb d3 ();

  logic [3:0]  d_stall;
  logic [3:0]  d_ack;
  logic [31:0] d_dat [4];

  assign d0.stall = d_stall[0];
  assign d1.stall = d_stall[1];
  assign d2.stall = d_stall[2];
  assign d3.stall = d_stall[3];
  assign d0.ack   = d_ack[0];
  assign d1.ack   = d_ack[1];
  assign d2.ack   = d_ack[2];
  assign d3.ack   = d_ack[3];
  assign d0.dat_r = d_dat[0];
  assign d1.dat_r = d_dat[1];
  assign d2.dat_r = d_dat[2];
  assign d3.dat_r = d_dat[3];

  logic [3:0]       o_stb;
  logic [3:0]       o_cyc;
  logic [3:0]       o_we;
  logic [3:0][31:0] o_adr;
  logic [3:0][3:0]  o_sel;
  logic [3:0][31:0] o_datw;

  assign o_stb  = {d3.stb, d2.stb, d1.stb, d0.stb};
  assign o_cyc  = {d3.cyc, d2.cyc, d1.cyc, d0.cyc};
  assign o_we   = {d3.we, d2.we, d1.we, d0.we};
  assign o_adr  = {d3.adr, d2.adr, d1.adr, d0.adr};
  assign o_sel  = {d3.sel, d2.sel, d1.sel, d0.sel};
  assign o_datw = {d3.dat_w, d2.dat_w, d1.dat_w, d0.dat_w};

  bus_decoder #(.DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .cpu_bus (cpu),
    .dev0    (d0),
    .dev1    (d1),
    .dev2    (d2),
    .dev3    (d3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic cyc, input logic stb, input logic we,
                                input logic [31:0] adr, input logic [3:0] sel,
                                input logic [31:0] dat);
    cpu.cyc   = cyc;
    cpu.stb   = stb;
    cpu.we    = we;
    cpu.adr   = adr;
    cpu.sel   = sel;
    cpu.dat_w = dat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      d_stall = '0;
      d_ack   = '0;
    end
  endtask

  // Reference model: outstanding targets held as a plain queue, outputs derived from the decode rules.
  logic [3:0] base_tab [4] = '{4'h0, 4'h2, 4'h3, 4'h8};
  int         q [$];

  always @(negedge clk) begin : compare
    int         mt;
    int         hd;
    bit         busy;
    bit         s_int;
    bit         e_stall;
    bit         e_ack;
    logic [31:0] e_dat;
    mt = 4;
    for (int k = 0; k < 4; k++)
      if (mt == 4 && cpu.adr[31:28] == base_tab[k]) mt = k;
    busy    = (q.size() != 0);
    hd      = busy ? q[0] : 7;
    s_int   = (q.size() == DEPTH) || (busy && hd != mt);
    e_stall = rst_i && (s_int || (mt < 4 && d_stall[mt]));
    e_ack   = rst_i && cpu.cyc && busy && (hd == 4 || (hd < 4 && d_ack[hd]));
    e_dat   = !e_ack ? 32'h0 : (hd == 4 ? 32'hDEADBEEF : d_dat[hd]);
    check_output("cpu_stall", {31'h0, cpu.stall}, {31'h0, e_stall});
    check_output("cpu_ack", {31'h0, cpu.ack}, {31'h0, e_ack});
    check_output("cpu_dat_r", cpu.dat_r, e_dat);
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("dev%0d_stb", k), {31'h0, o_stb[k]},
                   {31'h0, rst_i && cpu.cyc && cpu.stb && mt == k && !s_int});
      check_output($sformatf("dev%0d_cyc", k), {31'h0, o_cyc[k]},
                   {31'h0, rst_i && cpu.cyc && (mt == k || (busy && hd == k))});
      check_output($sformatf("dev%0d_bcast", k),
                   {o_adr[k] ^ o_datw[k], 27'h0, o_sel[k], o_we[k]} ,
                   {cpu.adr ^ cpu.dat_w, 27'h0, cpu.sel, cpu.we});
    end
    if (!rst_i || !cpu.cyc) begin
      q.delete();
    end else begin
      if (e_ack) void'(q.pop_front());
      if (cpu.stb && !e_stall) q.push_back(mt);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  int acc;
  int acks;

  initial begin
    rst_i   = 1'b0;
    d_stall = '0;
    d_ack   = '0;
    for (int k = 0; k < 4; k++) d_dat[k] = 32'h0;
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'hf, 32'h0);

    $display("[TB] reset state");
    #13;
    check_output("rst_stall", {31'h0, cpu.stall}, 32'h0);
    check_output("rst_dev0_stb", {31'h0, d0.stb}, 32'h0);
    check_output("rst_dev0_cyc", {31'h0, d0.cyc}, 32'h0);
    #10 rst_i = 1'b1;
    idle(2);

    $display("[TB] single mapped read");
    step(); apply_stimulus(1'b1, 1'b1, 1'b0, 32'h2000_0010, 4'hf, 32'h0);
    sample();
    check_output("t1_dev1_stb", {31'h0, d1.stb}, 32'h1);
    check_output("t1_stall", {31'h0, cpu.stall}, 32'h0);
    step(); cpu.stb = 1'b0; d_ack[1] = 1'b1; d_dat[1] = 32'h1234_5678;
    sample();
    check_output("t1_ack", {31'h0, cpu.ack}, 32'h1);
    check_output("t1_dat", cpu.dat_r, 32'h1234_5678);
    check_output("t1_dev1_stb_once", {31'h0, d1.stb}, 32'h0);
    step(); d_ack[1] = 1'b0; apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'hf, 32'h0);
    sample();
    check_output("t1_count_zero", {31'h0, cpu.stall}, 32'h0);
    step(); cpu.stb = 1'b0; d_ack[0] = 1'b1;
    sample();
    idle(2);

    $display("[TB] pipelined burst to full");
    acc = 0; acks = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      apply_stimulus(1'b1, acc < 6, 1'b0, 32'h0000_0040, 4'hf, 32'h0);
      d_ack[0] = (c >= 11) && (acks < 6);
      d_dat[0] = 32'hA000_0000 + 32'(acks);
      sample();
      if (c == 4)  check_output("t2_stall_c4", {31'h0, cpu.stall}, 32'h0);
      if (c == 5)  check_output("t2_stall_c5", {31'h0, cpu.stall}, 32'h1);
      if (c == 11) check_output("t2_stall_c11", {31'h0, cpu.stall}, 32'h1);
      if (c == 12) check_output("t2_stall_c12", {31'h0, cpu.stall}, 32'h0);
      if (cpu.stb && !cpu.stall) acc++;
      if (cpu.ack) begin
        check_output("t2_ack_dat", cpu.dat_r, 32'hA000_0000 + 32'(acks));
        acks++;
      end
    end
    check_output("t2_accepts", 32'(acc), 32'd6);
    check_output("t2_acks", 32'(acks), 32'd6);
    idle(2);

    $display("[TB] target switch");
    step(); apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0000_0004, 4'hf, 32'h0000_0055);
    sample();
    check_output("t3_dev0_stb", {31'h0, d0.stb}, 32'h1);
    step(); apply_stimulus(1'b1, 1'b1, 1'b0, 32'h8000_0000, 4'hf, 32'h0);
    sample();
    check_output("t3_dev3_hold", {31'h0, d3.stb}, 32'h0);
    check_output("t3_stall_hold", {31'h0, cpu.stall}, 32'h1);
    step(); d_ack[0] = 1'b1;
    sample();
    check_output("t3_ack0", {31'h0, cpu.ack}, 32'h1);
    check_output("t3_dev3_ackcyc", {31'h0, d3.stb}, 32'h0);
    step(); d_ack[0] = 1'b0;
    sample();
    check_output("t3_dev3_stb", {31'h0, d3.stb}, 32'h1);
    check_output("t3_dev3_we_sel", {27'h0, d3.sel, d3.we}, {27'h0, 4'hf, 1'b0});
    step(); cpu.stb = 1'b0; d_ack[3] = 1'b1; d_dat[3] = 32'h0BAD_F00D;
    sample();
    check_output("t3_dat3", cpu.dat_r, 32'h0BAD_F00D);
    idle(2);

    $display("[TB] unmapped accesses");
    step(); apply_stimulus(1'b1, 1'b1, 1'b0, 32'hF000_0000, 4'hf, 32'h0);
    sample();
    check_output("t4_no_stb", {28'h0, o_stb}, 32'h0);
    check_output("t4_ack_early", {31'h0, cpu.ack}, 32'h0);
    step(); apply_stimulus(1'b1, 1'b1, 1'b1, 32'hF000_0004, 4'hf, 32'h1111_2222);
    sample();
    check_output("t4_ack1", {31'h0, cpu.ack}, 32'h1);
    check_output("t4_dat1", cpu.dat_r, 32'hDEADBEEF);
    check_output("t4_no_stb2", {28'h0, o_stb}, 32'h0);
    step(); cpu.stb = 1'b0;
    sample();
    check_output("t4_ack2", {31'h0, cpu.ack}, 32'h1);
    step();
    sample();
    check_output("t4_ack_done", {31'h0, cpu.ack}, 32'h0);
    idle(2);

    $display("[TB] abort mid-flight");
    for (int i = 0; i < 3; i++) begin
      step(); apply_stimulus(1'b1, 1'b1, 1'b0, 32'h3000_0000 + 32'(4 * i), 4'hf, 32'h0);
      sample();
      check_output("t5_dev2_stb", {31'h0, d2.stb}, 32'h1);
    end
    step(); apply_stimulus(1'b0, 1'b0, 1'b0, 32'h3000_0000, 4'hf, 32'h0);
    d_ack[2] = 1'b1; d_dat[2] = 32'h7777_7777;
    sample();
    check_output("t5_ack_abort", {31'h0, cpu.ack}, 32'h0);
    check_output("t5_dev2_cyc", {31'h0, d2.cyc}, 32'h0);
    step(); cpu.cyc = 1'b1;
    sample();
    check_output("t5_late_ack", {31'h0, cpu.ack}, 32'h0);
    step(); d_ack[2] = 1'b0; apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_0100, 4'hf, 32'h0);
    sample();
    check_output("t5_next_stall", {31'h0, cpu.stall}, 32'h0);
    check_output("t5_next_stb", {31'h0, d0.stb}, 32'h1);
    step(); cpu.stb = 1'b0; d_ack[0] = 1'b1; d_dat[0] = 32'h0000_0ABC;
    sample();
    check_output("t5_next_ack", cpu.dat_r, 32'h0000_0ABC);
    idle(2);

    $display("[TB] async reset mid-burst");
    for (int i = 0; i < 2; i++) begin
      step(); apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_0200, 4'hf, 32'h0);
    end
    step(); d_ack[0] = 1'b1; d_dat[0] = 32'h5555_AAAA;
    #2 rst_i = 1'b0;
    #1;
    check_output("t6_ack", {31'h0, cpu.ack}, 32'h0);
    check_output("t6_stall", {31'h0, cpu.stall}, 32'h0);
    check_output("t6_stb", {28'h0, o_stb}, 32'h0);
    check_output("t6_cyc", {28'h0, o_cyc}, 32'h0);
    sample();
    step();
    step(); #1 rst_i = 1'b1; cpu.stb = 1'b0;
    sample();
    check_output("t6_ack_after", {31'h0, cpu.ack}, 32'h0);
    step(); d_ack[0] = 1'b0; apply_stimulus(1'b1, 1'b1, 1'b0, 32'h8000_0010, 4'hf, 32'h0);
    sample();
    check_output("t6_dev3_stb", {31'h0, d3.stb}, 32'h1);
    step(); cpu.stb = 1'b0; d_ack[3] = 1'b1; d_dat[3] = 32'h3333_0000;
    sample();
    check_output("t6_dev3_ack", {31'h0, cpu.ack}, 32'h1);
    idle(2);

    $display("[TB] random traffic");
    begin
      logic [3:0] reg_tab [6] = '{4'h0, 4'h2, 4'h3, 4'h8, 4'hF, 4'h5};
      for (int i = 0; i < 3000; i++) begin
        step();
        apply_stimulus(($urandom % 16) != 0, ($urandom % 4) != 0, 1'($urandom),
                       {reg_tab[$urandom_range(0, 5)], 28'($urandom)}, 4'($urandom), $urandom);
        for (int k = 0; k < 4; k++) begin
          d_stall[k] = ($urandom % 4) == 0;
          d_ack[k]   = ($urandom % 3) == 0;
          d_dat[k]   = $urandom;
        end
      end
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
